// File: rtl/pin_in_filter_pkg.sv
// pin_in_filter_pkg
//   Shared pin-count and filter-width constants for the input pin path, plus
//   the per-pin filter state type used by pin_in_filter.
package pin_in_filter_pkg;

    localparam int unsigned IN_PIN_NUM           = 8;
    localparam int unsigned OUT_PIN_NUM          = 8;
    localparam int unsigned PIN_FILTER_CNT_WIDTH = 4;

    // STABLE: synchronised level equals the held output level.
    // PENDING: synchronised level differs and is being qualified.
    typedef enum logic {
        PIN_STABLE  = 1'b0,
        PIN_PENDING = 1'b1
    } pin_state_e;

endpackage

// File: rtl/pin_in_filter_if.sv
// pin_in_filter_if
//   Groups the raw pad inputs, the filter configuration and the conditioned
//   outputs of pin_in_filter.
//   master : drives pins_i, filter_en_i, filter_cycles_i; receives outputs
//   slave  : the filter block itself
//   pins_i          raw asynchronous pad levels
//   filter_en_i     per-pin glitch filter enable
//   filter_cycles_i shared filter threshold N
//   pins_o          conditioned levels
//   rise_o / fall_o one-cycle edge pulses of pins_o
interface pin_in_filter_if #(
    parameter int unsigned NUM_PINS  = pin_in_filter_pkg::IN_PIN_NUM,
    parameter int unsigned CNT_WIDTH = pin_in_filter_pkg::PIN_FILTER_CNT_WIDTH
);

    logic [NUM_PINS-1:0]  pins_i;
    logic [NUM_PINS-1:0]  filter_en_i;
    logic [CNT_WIDTH-1:0] filter_cycles_i;
    logic [NUM_PINS-1:0]  pins_o;
    logic [NUM_PINS-1:0]  rise_o;
    logic [NUM_PINS-1:0]  fall_o;

    modport master (
        output pins_i, filter_en_i, filter_cycles_i,
        input  pins_o, rise_o, fall_o
    );

    modport slave (
        input  pins_i, filter_en_i, filter_cycles_i,
        output pins_o, rise_o, fall_o
    );

endinterface

// File: rtl/prim_flop_2sync.sv
// prim_flop_2sync
//   Two-flop synchroniser for asynchronous inputs.
//   clk_i      destination clock
//   rst_ni     asynchronous active-low reset
//   d_i        asynchronous input
//   q_o        synchronised output (second flop)
module prim_flop_2sync #(
    parameter int unsigned       Width      = 16,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] s1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1  <= ResetValue;
            q_o <= ResetValue;
        end else begin
            s1  <= d_i;
            q_o <= s1;
        end
    end

endmodule

// File: rtl/pin_in_filter.sv
// pin_in_filter
//   Synchronises raw pad inputs and applies a per-pin glitch filter: a pin's
//   output follows its synchronised level only after the level has differed
//   from the output for N+1 consecutive cycles (immediately when the filter
//   is disabled or N=0). Registered rise/fall pulses accompany each update.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (deassertion synchronised outside)
//   bus     pin_in_filter_if slave: pins_i, filter_en_i, filter_cycles_i in;
//           pins_o, rise_o, fall_o out
module pin_in_filter
    import pin_in_filter_pkg::*;
#(
    parameter int unsigned          NUM_PINS  = IN_PIN_NUM,
    parameter int unsigned          CNT_WIDTH = PIN_FILTER_CNT_WIDTH,
    parameter logic [NUM_PINS-1:0]  RESET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    pin_in_filter_if.slave   bus
);

    logic [NUM_PINS-1:0] s2;
    logic [NUM_PINS-1:0] q_vec;
    logic [NUM_PINS-1:0] rise_vec;
    logic [NUM_PINS-1:0] fall_vec;

    prim_flop_2sync #(
        .Width      (NUM_PINS),
        .ResetValue (RESET_VAL)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (bus.pins_i),
        .q_o    (s2)
    );

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        logic [CNT_WIDTH-1:0] cnt;
        logic                 q;
        logic                 rise;
        logic                 fall;
        logic                 take;
        pin_state_e           state;

        always_comb begin
            state = (s2[i] != q) ? PIN_PENDING : PIN_STABLE;
            // >= so that lowering the threshold below a pending count
            // releases the update on the very next edge.
            take  = !bus.filter_en_i[i] || (cnt >= bus.filter_cycles_i);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q    <= RESET_VAL[i];
                cnt  <= '0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                case (state)
                    PIN_STABLE: begin
                        cnt <= '0;
                    end
                    PIN_PENDING: begin
                        if (take) begin
                            q    <= s2[i];
                            cnt  <= '0;
                            rise <= s2[i];
                            fall <= !s2[i];
                        end else begin
                            // cnt < threshold here, so it cannot wrap.
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end

        assign q_vec[i]    = q;
        assign rise_vec[i] = rise;
        assign fall_vec[i] = fall;
    end

    assign bus.pins_o = q_vec;
    assign bus.rise_o = rise_vec;
    assign bus.fall_o = fall_vec;

endmodule

// File: tb/tb_pin_in_filter.sv
// tb_pin_in_filter
//   Randomised and directed stimulus for pin_in_filter. A reference model
//   predicts the outputs after every clock edge into a queue; a separate
//   monitor compares the DUT against the queue on each falling edge.
module tb_pin_in_filter;

  localparam int NP = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [NP-1:0] pins;
    logic [NP-1:0] rise;
    logic [NP-1:0] fall;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;

  pin_in_filter_if #(.NUM_PINS(NP), .CNT_WIDTH(CW)) bus ();

  pin_in_filter #(
    .NUM_PINS  (NP),
    .CNT_WIDTH (CW),
    .RESET_VAL ('1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: levels seen two edges late, and for each pin the
  // length of the current run of cycles in which that level disagreed
  // with the output level.
  logic [NP-1:0] m_s1 = '1;
  logic [NP-1:0] m_s2 = '1;
  logic [NP-1:0] m_q  = '1;
  int            streak [NP];
  obs_t          exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    m_s1 = '1;
    m_s2 = '1;
    m_q  = '1;
    for (int unsigned i = 0; i < NP; i++) streak[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    obs_t e;
    e.rise = '0;
    e.fall = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (m_s2[i] == m_q[i]) begin
        streak[i] = 0;
      end else begin
        streak[i] = streak[i] + 1;
        if (!bus.filter_en_i[i] || streak[i] > int'(bus.filter_cycles_i)) begin
          m_q[i]    = m_s2[i];
          e.rise[i] = m_s2[i];
          e.fall[i] = ~m_s2[i];
          streak[i] = 0;
        end
      end
    end
    m_s2   = m_s1;
    m_s1   = bus.pins_i;
    e.pins = m_q;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  // Assert reset between edges, hold for n edges, release just after an edge.
  task automatic reset_mid(input int unsigned n, input logic [NP-1:0] pins_during);
    #1;
    rst_n = 1'b0;
    model_reset();
    bus.pins_i = pins_during;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor
  initial begin
    obs_t exp_v;
    obs_t act;
    forever begin
      @(negedge clk);
      act = {bus.pins_o, bus.rise_o, bus.fall_o};
      n_checks++;
      if (!rst_n || exp_q.size() == 0) begin
        exp_v = '{pins: '1, rise: '0, fall: '0};
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL reset_state t=%0t: pins_o/rise_o/fall_o got %h/%h/%h expected %h/%h/%h",
                   $time, act.pins, act.rise, act.fall,
                   exp_v.pins, exp_v.rise, exp_v.fall);
        end
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL filter_out t=%0t: pins_o/rise_o/fall_o got %h/%h/%h expected %h/%h/%h",
                   $time, act.pins, act.rise, act.fall,
                   exp_v.pins, exp_v.rise, exp_v.fall);
        end
      end
    end
  end

  // Driver
  initial begin
    rst_n               = 1'b0;
    bus.pins_i          = '1;
    bus.filter_en_i     = '0;
    bus.filter_cycles_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Unfiltered pin 0 falling then rising.
    bus.pins_i[0] = 1'b0;
    tick(6);
    bus.pins_i[0] = 1'b1;
    tick(6);

    // Glitch shorter than N+1 is rejected, then a held low passes.
    bus.filter_en_i     = '1;
    bus.filter_cycles_i = 4'd4;
    bus.pins_i[2]       = 1'b0;
    tick(3);
    bus.pins_i[2]       = 1'b1;
    tick(10);
    bus.pins_i[2]       = 1'b0;
    tick(12);

    // Threshold lowered below a pending count, then max threshold.
    bus.filter_cycles_i = 4'd15;
    bus.pins_i[3]       = 1'b0;
    tick(8);
    bus.filter_cycles_i = 4'd2;
    tick(4);
    bus.filter_cycles_i = 4'd15;
    bus.pins_i[3]       = 1'b1;
    tick(22);

    // Filter disabled while pending.
    bus.pins_i[5] = 1'b0;
    tick(6);
    bus.filter_en_i[5] = 1'b0;
    tick(4);
    bus.pins_i[5] = 1'b1;
    tick(3);
    bus.filter_en_i = '1;

    // Reset in the middle of a pending count, released with pins high.
    bus.filter_cycles_i = 4'd8;
    bus.pins_i          = '1;
    tick(12);
    bus.pins_i[4]       = 1'b0;
    tick(6);
    reset_mid(2, '1);
    tick(6);

    // Simultaneous toggle on an unfiltered and a filtered pin.
    bus.filter_en_i     = 8'h80;
    bus.filter_cycles_i = 4'd1;
    bus.pins_i[0]       = 1'b0;
    bus.pins_i[7]       = 1'b0;
    tick(6);

    // Random blocks over a spread of thresholds and toggle rates.
    for (int unsigned blk = 0; blk < 12; blk++) begin
      int unsigned rate;
      bus.filter_en_i = 8'($urandom);
      case (blk % 4)
        0:       bus.filter_cycles_i = 4'd0;
        1:       bus.filter_cycles_i = 4'd15;
        default: bus.filter_cycles_i = 4'($urandom_range(0, 15));
      endcase
      rate = (blk % 3 == 0) ? 24 : 4;
      for (int unsigned c = 0; c < 50; c++) begin
        for (int unsigned i = 0; i < NP; i++)
          if ($urandom_range(0, rate) == 0) bus.pins_i[i] = ~bus.pins_i[i];
        if ($urandom_range(0, 19) == 0)
          bus.filter_cycles_i = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 29) == 0)
          bus.filter_en_i[$urandom_range(0, NP - 1)] = 1'($urandom);
        if (blk == 7 && c == 25)
          reset_mid(1, 8'($urandom));
        tick(1);
      end
    end

    tick(3);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL expired_wait t=%0t: %0d predicted observations never checked",
               $time, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
